// File: rtl/slicer_pkg.sv
// Shared widths and FSM state type for the slicer input arbiter.
package slicer_pkg;

    localparam int unsigned W      = 11;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = W - ADDR_W;

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first valid requester at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/slicer_input_arbiter.sv
// Round-robin arbiter feeding one output register toward the bitslicer.
// Optional feature: define SLICER_ARB_PRIO_EN to let all-ones-address packets pre-empt round-robin.
module slicer_input_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned W      = slicer_pkg::W,
    parameter int unsigned ADDR_W = slicer_pkg::ADDR_W,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [IDX_W-1:0]   out_src,
    input  logic               out_ready,
    output logic [15:0]        pkt_count
);

    import slicer_pkg::*;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [IDX_W-1:0] out_src_q, out_src_d;
    logic [15:0]      pkt_count_q, pkt_count_d;

    logic [N_REQ-1:0] rr_grant;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_any;

    logic [N_REQ-1:0] win_grant;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic             rr_update;

    logic             arb_en;
    logic             granted;
    logic             out_xfer;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

`ifdef SLICER_ARB_PRIO_EN
    logic [N_REQ-1:0] prio_valid;
    logic [N_REQ-1:0] prio_grant;
    logic [IDX_W-1:0] prio_idx;
    logic             prio_any;
    logic [IDX_W-1:0] prio_ptr;

    assign prio_ptr = '0;

    always_comb begin
        prio_valid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            prio_valid[i] = req_valid[i] && (req_data[i*W + W - ADDR_W +: ADDR_W] == '1);
        end
    end

    // Pointer fixed at zero gives lowest-index-first among priority packets.
    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_prio_pick (
        .valid (prio_valid),
        .ptr   (prio_ptr),
        .grant (prio_grant),
        .idx   (prio_idx),
        .any   (prio_any)
    );

    assign win_grant = prio_any ? prio_grant : rr_grant;
    assign win_idx   = prio_any ? prio_idx   : rr_idx;
    assign win_any   = rr_any;
    assign rr_update = !prio_any;
`else
    assign win_grant = rr_grant;
    assign win_idx   = rr_idx;
    assign win_any   = rr_any;
    assign rr_update = 1'b1;
`endif

    assign out_xfer = (state_q == StFull) && out_ready;
    // Reset gates the handshake so no requester sees a grant while state is being cleared.
    assign arb_en   = !RESET && ((state_q == StEmpty) || out_ready);
    assign granted  = arb_en && win_any;

    assign req_ready = granted ? win_grant : '0;
    assign out_valid = (state_q == StFull);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign pkt_count = pkt_count_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        pkt_count_d = pkt_count_q;

        unique case (state_q)
            StEmpty: if (granted) state_d = StFull;
            StFull:  if (out_ready && !granted) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase

        if (granted) begin
            out_data_d = req_data[int'(win_idx)*W +: W];
            out_src_d  = win_idx;
            if (rr_update) begin
                rr_ptr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
            end
        end

        if (out_xfer) pkt_count_d = pkt_count_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StEmpty;
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule
